// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the time-shared four-in-a-row detector.
//   state_t        : 4-bit detector state, A = start, B..E = run of 1..4+ zeros,
//                    F..I = run of 1..4+ ones
//   NUM_CH_DEFAULT : default channel count
//   CNT_W          : width of each per-channel match counter
package seq_detect_pkg;

    typedef enum logic [3:0] {
        ST_A = 4'd0,
        ST_B = 4'd1,
        ST_C = 4'd2,
        ST_D = 4'd3,
        ST_E = 4'd4,
        ST_F = 4'd5,
        ST_G = 4'd6,
        ST_H = 4'd7,
        ST_I = 4'd8
    } state_t;

    localparam int unsigned NUM_CH_DEFAULT = 4;
    localparam int unsigned CNT_W          = 8;

endpackage

// File: rtl/seq4_core.sv
// Combinational four-in-a-row detector step, shared by all channels.
// Ports:
//   state      : current state of the channel being serviced
//   w          : that channel's sample bit
//   next_state : state after consuming w
//   z          : next_state completes a run of four equal bits (E or I)
module seq4_core
    import seq_detect_pkg::*;
(
    input  state_t state,
    input  logic   w,
    output state_t next_state,
    output logic   z
);

    always_comb begin
        next_state = ST_A;
        if (!w) begin
            case (state)
                ST_B:       next_state = ST_C;
                ST_C:       next_state = ST_D;
                ST_D, ST_E: next_state = ST_E;
                default:    next_state = ST_B;  // A, F..I and unused codes start a zero run
            endcase
        end else begin
            case (state)
                ST_F:       next_state = ST_G;
                ST_G:       next_state = ST_H;
                ST_H, ST_I: next_state = ST_I;
                default:    next_state = ST_F;  // A, B..E and unused codes start a one run
            endcase
        end
        z = (next_state == ST_E) || (next_state == ST_I);
    end

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler that time-shares one seq4_core across NUM_CH channels.
// Each channel keeps its own state register; one channel is serviced per cycle
// and its result is presented, registered, on the following cycle.
// Ports:
//   Clock, Reset : single clock, synchronous active-high reset
//   req          : per-channel sample pending (held until grant)
//   w            : per-channel sample bit
//   clr          : per-channel restart to state A (beats a same-cycle req)
//   grant        : one-hot, channel whose sample was consumed last cycle
//   z            : per-channel, consumed sample completed a run of four
//   busy         : a grant is being presented this cycle
//   state_dbg    : new state of the last serviced channel
//   match_cnt    : only with SEQ_DETECT_SCHED_MATCH_CNT_EN defined; 8-bit
//                  saturating count of z pulses per channel
module seq_detect_sched
    import seq_detect_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] w,
    input  logic [NUM_CH-1:0] clr,
    output logic [NUM_CH-1:0] grant,
    output logic [NUM_CH-1:0] z,
    output logic              busy,
    output logic [3:0]        state_dbg
`ifdef SEQ_DETECT_SCHED_MATCH_CNT_EN
   ,output logic [NUM_CH*CNT_W-1:0] match_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(NUM_CH);

    state_t            state_q [NUM_CH];
    logic [NUM_CH-1:0] grant_q;
    logic [NUM_CH-1:0] z_q;
    logic              busy_q;
    state_t            dbg_q;
    logic [PTR_W-1:0]  ptr_q;

    logic [NUM_CH-1:0] eligible;
    logic              sel_valid;
    logic [PTR_W-1:0]  sel_idx;
    logic [PTR_W:0]    cand;
    state_t            core_state;
    logic              core_w;
    state_t            core_next;
    logic              core_z;
    logic [NUM_CH-1:0] grant_d;
    logic [NUM_CH-1:0] z_d;

    // A channel granted last cycle is still showing its old req; skip it.
    assign eligible = req & ~clr & ~grant_q;

    // Round-robin search starting at the channel after the last granted one.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= int'(NUM_CH); i++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_CH)) begin
                cand = cand - (PTR_W+1)'(NUM_CH);
            end
            if (!sel_valid && eligible[cand[PTR_W-1:0]]) begin
                sel_valid = 1'b1;
                sel_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign core_state = state_q[sel_idx];
    assign core_w     = w[sel_idx];

    seq4_core u_core (
        .state      (core_state),
        .w          (core_w),
        .next_state (core_next),
        .z          (core_z)
    );

    always_comb begin
        grant_d = '0;
        z_d     = '0;
        if (sel_valid) begin
            grant_d[sel_idx] = 1'b1;
            z_d[sel_idx]     = core_z;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                state_q[k] <= ST_A;
            end
            grant_q <= '0;
            z_q     <= '0;
            busy_q  <= 1'b0;
            dbg_q   <= ST_A;
            ptr_q   <= PTR_W'(NUM_CH - 1);
        end else begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (clr[k]) begin
                    state_q[k] <= ST_A;
                end else if (grant_d[k]) begin
                    state_q[k] <= core_next;
                end
            end
            grant_q <= grant_d;
            z_q     <= z_d;
            busy_q  <= sel_valid;
            if (sel_valid) begin
                dbg_q <= core_next;
                ptr_q <= sel_idx;
            end
        end
    end

    assign grant     = grant_q;
    assign z         = z_q;
    assign busy      = busy_q;
    assign state_dbg = dbg_q;

`ifdef SEQ_DETECT_SCHED_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    // Counts at the end of each cycle that presents z for the channel.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (clr[k]) begin
                    cnt_q[k] <= '0;
                end else if (z_q[k] && (cnt_q[k] != '1)) begin
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_cnt_out
        assign match_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
`endif

endmodule

// File: doc/seq_detect_sched.md
SEQ_DETECT_SCHED -- requirements
Module: seq_detect_sched

Interface
REQ-001 The parameter list SHALL be: NUM_CH, default 4, number of requesting channels (2..8).
REQ-002 The ports SHALL be:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- req  in  NUM_CH  channel has a sample pending
- w  in  NUM_CH  sample bit for each channel
- clr  in  NUM_CH  restart the channel detector to state A
- grant  out  NUM_CH  one-hot, registered; the channel's sample was consumed
- z  out  NUM_CH  registered; the consumed sample completed a run of four equal bits
- busy  out  1  registered; some grant was issued this cycle
- state_dbg  out  4  registered state code of the last serviced channel
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high on port Reset, with Clock as the only clock.

Function
REQ-004 The block SHALL time-share one four-in-a-row detector core across NUM_CH channels. Each channel SHALL keep its own 4-bit state register.
REQ-005 The detector states SHALL be A=0 (start), B, C, D, E=1..4 (run of 1..4+ zeros) and F, G, H, I=5..8 (run of 1..4+ ones).
REQ-006 Next-state rules SHALL be:
- w=0: from A or F..I go to B; B to C; C to D; D or E go to E.
- w=1: from A or B..E go to F; F to G; G to H; H or I go to I.
REQ-007 A channel SHALL be eligible in cycle t when req=1, clr=0 and grant for that channel was 0 in cycle t.
REQ-008 Arbitration SHALL be round-robin. Search SHALL start at the channel after the last granted one. At most one channel SHALL be serviced per cycle.
REQ-009 When channel k is serviced in cycle t:
- at the edge ending t, state[k] SHALL take next_state(state[k], w[k]);
- in cycle t+1, grant[k]=1 and busy=1;
- in cycle t+1, z[k]=1 iff the new state is E or I;
- in cycle t+1, state_dbg shows the new state.
REQ-010 Latency SHALL be one cycle from sample to grant and z. Sustained throughput SHALL be one sample per cycle across all channels.
REQ-011 A requester SHALL hold req and w until grant. The req seen in the grant cycle SHALL be ignored (REQ-007), so a channel can be serviced at most every second cycle.
REQ-012 When no channel is eligible, grant, z and busy SHALL be 0. state_dbg and the round-robin pointer SHALL hold.
REQ-013 clr[k]=1 SHALL force state[k] to A at the next edge. It SHALL take priority over a same-cycle request, and that sample SHALL be neither consumed nor granted.
REQ-014 The round-robin pointer SHALL wrap from NUM_CH-1 to 0.

Reset
REQ-015 Reset SHALL force, at the next edge:
- every channel state to A;
- grant, z and busy to 0;
- state_dbg to 0;
- the round-robin pointer to NUM_CH-1, so channel 0 has first priority.
REQ-016 Reset SHALL take priority over clr and req. A sample pending when Reset is asserted SHALL be discarded without a grant.

Configuration
REQ-017 With SEQ_DETECT_SCHED_MATCH_CNT_EN defined:
- the block SHALL add output port match_cnt (NUM_CH*8 bits, 8 bits per channel);
- each channel count SHALL increment in the cycle its z is 1 and saturate at 255;
- each count SHALL clear to 0 on Reset or on clr for that channel.
REQ-018 Without SEQ_DETECT_SCHED_MATCH_CNT_EN, the match_cnt port and the counters SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-019 Package seq_detect_pkg SHALL hold:
- the 4-bit state type and codes ST_A..ST_I;
- constant NUM_CH_DEFAULT=4;
- constant CNT_W=8.
REQ-020 The next-state and z logic SHALL be one combinational sub-module, seq4_core (inputs state and w; outputs next_state and z), instanced once. The arbiter, per-channel state registers and counters SHALL reside in seq_detect_sched.

Verification
REQ-021 Reset, then req[0]=1 with w[0]=0 held across four grants: grants on cycles 2, 4, 6, 8; z[0]=0,0,0,1; state_dbg=1,2,3,4.
REQ-022 Channel 0 in state E with w=0, then w=1: z[0]=1 and state_dbg=4, then z[0]=0 and state_dbg=5 (F).
REQ-023 req=4'b1111 held continuously: grant sequence 0001, 0010, 0100, 1000, 0001; busy=1 every cycle.
REQ-024 Channel 2 in state H with clr[2]=1 and req[2]=1 in the same cycle: no grant[2]; state returns to A; the next w=1 sample gives state_dbg=5 and z[2]=0.
REQ-025 Reset asserted for one cycle mid-stream with req=4'b0011: grant=0 the cycle after; all states A; channel 0 is granted first after release.
REQ-026 With SEQ_DETECT_SCHED_MATCH_CNT_EN defined, channel 1 held at w=1 for 600 samples: match_cnt[15:8] saturates at 255, then a clr[1] pulse returns it to 0.
